core_clk_ctrl: RTL and testbench

Per-core clock-gating policy controller for the four-core multicore. Sits directly upstream of the multicore's `clock_disable[3:0]` input and replaces the bench-driven pattern with a decision derived from each core's FIFO status and write traffic. A core's clock is gated after a run of idle cycles and released as soon as work arrives. A saturating counter reports the accumulated gated core-cycles.

---
 rtl/core_clk_ctrl.sv | 138 +++++++++++++
 tb/tb_core_clk_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/core_clk_ctrl.sv
// Per-core clock-gating policy: gates an idle core after a run of idle samples,
// wakes it the edge after work appears, and accumulates gated core-cycles.

module core_clk_ctrl_lane #(
  parameter int IDLE_THRESH = 4,
  parameter int MIN_ON      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic idle,
  input  logic force_off,
  output logic gated,
  output logic wake
);
  localparam int IW = (IDLE_THRESH > 1) ? $clog2(IDLE_THRESH) : 1;
  localparam int HW = (MIN_ON > 1) ? $clog2(MIN_ON) : 1;

  typedef enum logic [1:0] {RUN, GATED, WAKE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idle_cnt, idle_cnt_nxt;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;
  logic          wake_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      idle_cnt <= '0;
      hold_cnt <= '0;
      wake     <= 1'b0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_cnt_nxt;
      hold_cnt <= hold_cnt_nxt;
      wake     <= wake_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    hold_cnt_nxt = hold_cnt;
    wake_nxt     = 1'b0;
    if (!enable) begin
      state_nxt    = RUN;
      idle_cnt_nxt = '0;
      hold_cnt_nxt = '0;
    end else if (force_off) begin
      // forced gating never pulses wake; release re-enters the normal GATED rule
      state_nxt    = GATED;
      idle_cnt_nxt = '0;
      hold_cnt_nxt = '0;
    end else begin
      case (state)
        RUN: begin
          if (!idle) idle_cnt_nxt = '0;
          else if (idle_cnt == IW'(IDLE_THRESH - 1)) begin
            state_nxt    = GATED;
            idle_cnt_nxt = '0;
          end else idle_cnt_nxt = idle_cnt + IW'(1);
        end
        GATED: begin
          if (!idle) begin
            state_nxt    = WAKE;
            hold_cnt_nxt = HW'(MIN_ON - 1);
            wake_nxt     = 1'b1;
          end
        end
        WAKE: begin
          if (hold_cnt == '0) begin
            state_nxt    = RUN;
            idle_cnt_nxt = '0;
          end else hold_cnt_nxt = hold_cnt - HW'(1);
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign gated = (state == GATED);
endmodule

module core_clk_ctrl #(
  parameter int IDLE_THRESH = 4,
  parameter int MIN_ON      = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [3:0]       data_empty,
  input  logic [3:0]       data_full,
  input  logic             wr_en0,
  input  logic             wr_en1,
  input  logic             wr_en2,
  input  logic             wr_en3,
  input  logic [3:0]       force_off,
  output logic [3:0]       clock_disable,
  output logic [3:0]       wake_event,
  output logic [CNT_W-1:0] gated_cycles
);
  localparam int NUM_CORES = 4;

  logic [NUM_CORES-1:0] wr_en, idle;
  logic [2:0]           pop;
  logic [CNT_W+2:0]     sum;
  logic [CNT_W-1:0]     gated_cycles_nxt;

  assign wr_en = {wr_en3, wr_en2, wr_en1, wr_en0};
  // a full FIFO is never empty, so the full term only reinforces non-idle
  assign idle  = data_empty & ~data_full & ~wr_en;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
    core_clk_ctrl_lane #(.IDLE_THRESH(IDLE_THRESH), .MIN_ON(MIN_ON)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .idle     (idle[i]),
      .force_off(force_off[i]),
      .gated    (clock_disable[i]),
      .wake     (wake_event[i])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CORES; i++) pop = pop + {2'b00, clock_disable[i]};
    sum = {3'b000, gated_cycles} + {{CNT_W{1'b0}}, pop};
    if (sum > {3'b000, {CNT_W{1'b1}}}) gated_cycles_nxt = '1;
    else                               gated_cycles_nxt = sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         gated_cycles <= '0;
    else if (enable) gated_cycles <= gated_cycles_nxt;
  end
endmodule

// File: tb/tb_core_clk_ctrl.sv
// Bench for core_clk_ctrl: directed vector table, saturation and async-reset
// sequences, then random traffic against a cycle-level policy model.

module tb_core_clk_ctrl;
  localparam int IDLE_THRESH = 4;
  localparam int MIN_ON      = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [3:0]  empty = 4'hF, full = 4'h0, wr = 4'h0, fo = 4'h0;
  logic [3:0]  cd, wk, cd_s, wk_s;
  logic [15:0] gc;
  logic [3:0]  gc_s;

  int vectors = 0, miscompares = 0;

  // model state
  bit [3:0] m_gated, m_wake;
  int       m_streak[4], m_hold_end[4];
  int       m_gc16, m_gc4, t;

  always #5 clk = ~clk;

  core_clk_ctrl #(.IDLE_THRESH(IDLE_THRESH), .MIN_ON(MIN_ON), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enable(en), .data_empty(empty), .data_full(full),
    .wr_en0(wr[0]), .wr_en1(wr[1]), .wr_en2(wr[2]), .wr_en3(wr[3]),
    .force_off(fo), .clock_disable(cd), .wake_event(wk), .gated_cycles(gc));

  core_clk_ctrl #(.IDLE_THRESH(IDLE_THRESH), .MIN_ON(MIN_ON), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .enable(en), .data_empty(empty), .data_full(full),
    .wr_en0(wr[0]), .wr_en1(wr[1]), .wr_en2(wr[2]), .wr_en3(wr[3]),
    .force_off(fo), .clock_disable(cd_s), .wake_event(wk_s), .gated_cycles(gc_s));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    m_gated = '0; m_wake = '0; m_gc16 = 0; m_gc4 = 0;
    for (int n = 0; n < 4; n++) begin m_streak[n] = 0; m_hold_end[n] = -1; end
  endtask

  // Policy from the rules: count idle samples, gate on the threshold-th,
  // wake on any work, then ignore idleness through edge wake+MIN_ON.
  task automatic model_step();
    int pop;
    bit idle;
    pop = $countones(m_gated);
    if (en) begin
      m_gc16 = (m_gc16 + pop > 65535) ? 65535 : m_gc16 + pop;
      m_gc4  = (m_gc4 + pop > 15) ? 15 : m_gc4 + pop;
    end
    for (int n = 0; n < 4; n++) begin
      idle = empty[n] & ~wr[n];
      m_wake[n] = 1'b0;
      if (!en) begin
        m_gated[n] = 1'b0; m_streak[n] = 0; m_hold_end[n] = -1;
      end else if (fo[n]) begin
        m_gated[n] = 1'b1; m_streak[n] = 0; m_hold_end[n] = -1;
      end else if (m_gated[n]) begin
        if (!idle) begin
          m_gated[n] = 1'b0; m_wake[n] = 1'b1; m_streak[n] = 0; m_hold_end[n] = t + MIN_ON;
        end
      end else if (t <= m_hold_end[n]) begin
        m_streak[n] = 0;
      end else if (idle) begin
        m_streak[n]++;
        if (m_streak[n] == IDLE_THRESH) begin m_gated[n] = 1'b1; m_streak[n] = 0; end
      end else m_streak[n] = 0;
    end
    t++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("clock_disable_model", 32'(cd), 32'(m_gated));
    chk("wake_event_model", 32'(wk), 32'(m_wake));
    chk("gated_cycles16_model", 32'(gc), 32'(m_gc16));
    chk("gated_cycles4_model", 32'(gc_s), 32'(m_gc4));
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_async_cd", 32'({cd, cd_s}), 32'h0);
    chk("rst_async_wake", 32'({wk, wk_s}), 32'h0);
    chk("rst_async_gc", 32'({gc, gc_s}), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drive(input logic e, input logic [3:0] em, input logic [3:0] w, input logic [3:0] f);
    en = e; empty = em; wr = w; fo = f;
    full = ~em & 4'($urandom);
  endtask

  typedef struct packed {
    logic       en;
    logic [3:0] empty, wr, fo, cd, wk;
  } vec_t;
  vec_t tbl[27];

  int exp16[5] = '{4, 8, 12, 16, 20};
  int exp4[5]  = '{4, 8, 12, 15, 15};

  initial begin
    tbl[0]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0};
    tbl[4]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0};
    tbl[5]  = '{1'b1, 4'hF, 4'h4, 4'h0, 4'hB, 4'h4};
    tbl[6]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'hB, 4'h0};
    tbl[7]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'hB, 4'h0};
    tbl[8]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'hB, 4'h0};
    tbl[9]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'hB, 4'h0};
    tbl[10] = '{1'b1, 4'hF, 4'h0, 4'h0, 4'hB, 4'h0};
    tbl[11] = '{1'b1, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0};
    tbl[12] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[13] = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[14] = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[15] = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[16] = '{1'b1, 4'hF, 4'h2, 4'h0, 4'hD, 4'h0};
    tbl[17] = '{1'b1, 4'hF, 4'h0, 4'h0, 4'hD, 4'h0};
    tbl[18] = '{1'b1, 4'hF, 4'h0, 4'h0, 4'hD, 4'h0};
    tbl[19] = '{1'b1, 4'hF, 4'h0, 4'h0, 4'hD, 4'h0};
    tbl[20] = '{1'b1, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0};
    tbl[21] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[22] = '{1'b1, 4'h7, 4'h0, 4'h8, 4'h8, 4'h0};
    tbl[23] = '{1'b1, 4'h7, 4'h0, 4'h8, 4'h8, 4'h0};
    tbl[24] = '{1'b1, 4'h7, 4'h0, 4'h0, 4'h0, 4'h8};
    tbl[25] = '{1'b1, 4'h7, 4'h0, 4'h0, 4'h7, 4'h0};
    tbl[26] = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h7, 4'h0};

    t = 0;
    apply_reset();

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].en, tbl[i].empty, tbl[i].wr, tbl[i].fo);
      tick();
      chk($sformatf("tbl%0d_clock_disable", i), 32'(cd), 32'(tbl[i].cd));
      chk($sformatf("tbl%0d_wake_event", i), 32'(wk), 32'(tbl[i].wk));
    end

    // saturation of the narrow counter, then enable drop holds the totals
    apply_reset();
    drive(1'b1, 4'hF, 4'h0, 4'h0);
    repeat (4) tick();
    chk("all_idle_gated", 32'(cd), 32'hF);
    chk("gc_zero_at_gate", 32'(gc), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("gc16_step%0d", i), 32'(gc), 32'(exp16[i]));
      chk($sformatf("gc4_step%0d", i), 32'(gc_s), 32'(exp4[i]));
    end
    drive(1'b0, 4'hF, 4'h0, 4'h0);
    tick();
    chk("disable_cd", 32'(cd), 32'h0);
    chk("disable_gc16_hold", 32'(gc), 32'd20);
    chk("disable_gc4_hold", 32'(gc_s), 32'd15);

    // async reset while every core is gated and the count is running
    drive(1'b1, 4'hF, 4'h0, 4'h0);
    repeat (9) tick();
    chk("pre_reset_gated", 32'(cd), 32'hF);
    apply_reset();

    // random traffic, force and enable toggling
    fo = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] e, w;
      for (int n = 0; n < 4; n++) begin
        e[n] = ($urandom_range(0, 7) != 0);
        w[n] = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 15) == 0) fo = 4'($urandom) & 4'($urandom);
      drive($urandom_range(0, 39) != 0, e, w, fo);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
